data_memory_unit: RTL and testbench

Synthesizable 256 x 16-bit unified memory that sits directly downstream of the 3-stage Processor and serves its fetch port and its load/store handshake (readReq/writeReq/valueReady). Instruction reads are asynchronous. Data reads and writes complete after fixed, parameterised latencies, sequenced by a small state machine with one-deep pending slots for overlapping requests. A side-band preload port lets benches initialise contents without using the processor handshake.

---
 rtl/data_memory_unit_if.sv | 21 ++
 rtl/data_memory_unit.sv | 189 ++++++++++++++++++
 tb/tb_data_memory_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_unit_if.sv
// Load/store bus between the processor (master) and the data memory (slave).
interface data_memory_unit_if;
  logic [7:0]  memAddrLoadStore;
  logic [15:0] memStoreVal;
  logic [15:0] memLoadVal;
  logic        valueReady;
  logic        readReq;
  logic        writeReq;
  logic        busy;
  logic        reqOverflow;

  modport master (
    output memAddrLoadStore, memStoreVal, readReq, writeReq,
    input  memLoadVal, valueReady, busy, reqOverflow
  );

  modport slave (
    input  memAddrLoadStore, memStoreVal, readReq, writeReq,
    output memLoadVal, valueReady, busy, reqOverflow
  );
endinterface

// File: rtl/data_memory_unit.sv
// 256 x 16 unified memory: async instruction fetch, fixed-latency edge-triggered
// loads/stores with one-deep pending slots, and a side-band preload port.
module data_memory_unit #(
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           instr_addr,
  output logic [15:0]          instr,
  data_memory_unit_if.slave    bus,
  input  logic                 loadEn,
  input  logic [7:0]           loadAddr,
  input  logic [15:0]          loadData
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  localparam logic [7:0] RD_CNT = 8'(READ_LATENCY - 1);
  localparam logic [7:0] WR_CNT = 8'(WRITE_LATENCY - 1);

  logic [15:0] mem [256];

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        rd_q;
  logic        wr_q;
  logic        pend_rd;
  logic [7:0]  pend_rd_addr;
  logic        pend_wr;
  logic [7:0]  pend_wr_addr;
  logic [15:0] pend_wr_data;
  logic [15:0] load_val;
  logic        value_ready;
  logic        overflow;

  logic        rd_edge;
  logic        wr_edge;
  logic        commit;
  logic        drop;
  logic        np_rd;
  logic [7:0]  np_rd_addr;
  logic        np_wr;
  logic [7:0]  np_wr_addr;
  logic [15:0] np_wr_data;

  assign rd_edge = bus.readReq & ~rd_q;
  assign wr_edge = bus.writeReq & ~wr_q;
  assign commit  = (state == WR_WAIT) && (cnt == 8'd0) && !rst;

  assign instr           = mem[instr_addr];
  assign bus.memLoadVal  = load_val;
  assign bus.valueReady  = value_ready;
  assign bus.busy        = (state != IDLE);
  assign bus.reqOverflow = overflow;

  // Edges arriving while busy are folded into the pending slots first, so a
  // request landing on a completion posedge can be started immediately.
  always_comb begin
    np_rd      = pend_rd;
    np_rd_addr = pend_rd_addr;
    np_wr      = pend_wr;
    np_wr_addr = pend_wr_addr;
    np_wr_data = pend_wr_data;
    drop       = 1'b0;
    if (state != IDLE) begin
      if (rd_edge) begin
        if (pend_rd) begin
          drop = 1'b1;
        end else begin
          np_rd      = 1'b1;
          np_rd_addr = bus.memAddrLoadStore;
        end
      end
      if (wr_edge) begin
        if (pend_wr) begin
          drop = 1'b1;
        end else begin
          np_wr      = 1'b1;
          np_wr_addr = bus.memAddrLoadStore;
          np_wr_data = bus.memStoreVal;
        end
      end
    end
  end

  // Preload is ordered after the commit so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[addr] <= data;
    end
    if (loadEn) begin
      mem[loadAddr] <= loadData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      addr         <= 8'd0;
      data         <= 16'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      pend_rd      <= 1'b0;
      pend_rd_addr <= 8'd0;
      pend_wr      <= 1'b0;
      pend_wr_addr <= 8'd0;
      pend_wr_data <= 16'd0;
      load_val     <= 16'd0;
      value_ready  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      rd_q         <= bus.readReq;
      wr_q         <= bus.writeReq;
      pend_rd      <= np_rd;
      pend_rd_addr <= np_rd_addr;
      pend_wr      <= np_wr;
      pend_wr_addr <= np_wr_addr;
      pend_wr_data <= np_wr_data;
      if (drop) begin
        overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (wr_edge) begin
            addr  <= bus.memAddrLoadStore;
            data  <= bus.memStoreVal;
            cnt   <= WR_CNT;
            state <= WR_WAIT;
            if (rd_edge) begin
              pend_rd      <= 1'b1;
              pend_rd_addr <= bus.memAddrLoadStore;
            end
          end else if (rd_edge) begin
            addr        <= bus.memAddrLoadStore;
            value_ready <= 1'b0;
            cnt         <= RD_CNT;
            state       <= RD_WAIT;
          end
        end
        WR_WAIT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (np_rd) begin
            addr        <= np_rd_addr;
            value_ready <= 1'b0;
            cnt         <= RD_CNT;
            pend_rd     <= 1'b0;
            state       <= RD_WAIT;
          end else if (np_wr) begin
            addr    <= np_wr_addr;
            data    <= np_wr_data;
            cnt     <= WR_CNT;
            pend_wr <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            load_val    <= mem[addr];
            value_ready <= 1'b1;
            if (np_wr) begin
              addr    <= np_wr_addr;
              data    <= np_wr_data;
              cnt     <= WR_CNT;
              pend_wr <= 1'b0;
              state   <= WR_WAIT;
            end else if (np_rd) begin
              // The completing read keeps valueReady so its data is not lost.
              addr    <= np_rd_addr;
              cnt     <= RD_CNT;
              pend_rd <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench: instance a uses default latencies, instance b uses
// READ_LATENCY=4 / WRITE_LATENCY=3 for the overflow and reset-abort cases.
module tb_data_memory_unit;

  logic        clk;
  logic        rst_a, rst_b;
  logic [7:0]  instr_addr_a, instr_addr_b;
  logic [15:0] instr_a, instr_b;
  logic        load_en_a, load_en_b;
  logic [7:0]  load_addr_a, load_addr_b;
  logic [15:0] load_data_a, load_data_b;

  data_memory_unit_if bus_a ();
  data_memory_unit_if bus_b ();

  data_memory_unit u_dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .instr_addr (instr_addr_a),
    .instr      (instr_a),
    .bus        (bus_a),
    .loadEn     (load_en_a),
    .loadAddr   (load_addr_a),
    .loadData   (load_data_a)
  );

  data_memory_unit #(.READ_LATENCY(4), .WRITE_LATENCY(3)) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .instr_addr (instr_addr_b),
    .instr      (instr_b),
    .bus        (bus_b),
    .loadEn     (load_en_b),
    .loadAddr   (load_addr_b),
    .loadData   (load_data_b)
  );

  int          assertions = 0;
  int          failures   = 0;
  logic [15:0] model_a [256];
  logic [15:0] model_b [256];
  logic [15:0] exp_a [$];
  logic [15:0] exp_b [$];
  logic        vr_prev_a = 1'b0;
  logic        vr_prev_b = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; the request is sampled at the next posedge and
  // released at the following negedge.
  task automatic applyStimulus(input bit sel, input logic rd, input logic wr,
                               input logic [7:0] addr, input logic [15:0] data);
    if (!sel) begin
      if (wr) model_a[addr] = data;
      if (rd) exp_a.push_back(model_a[addr]);
      bus_a.memAddrLoadStore = addr;
      bus_a.memStoreVal      = data;
      bus_a.readReq          = rd;
      bus_a.writeReq         = wr;
    end else begin
      if (wr) model_b[addr] = data;
      if (rd) exp_b.push_back(model_b[addr]);
      bus_b.memAddrLoadStore = addr;
      bus_b.memStoreVal      = data;
      bus_b.readReq          = rd;
      bus_b.writeReq         = wr;
    end
    @(negedge clk);
    bus_a.readReq  = 1'b0;
    bus_a.writeReq = 1'b0;
    bus_b.readReq  = 1'b0;
    bus_b.writeReq = 1'b0;
  endtask

  task automatic applyPreload(input bit sel, input logic [7:0] addr, input logic [15:0] data);
    if (!sel) begin
      model_a[addr] = data;
      load_en_a = 1'b1; load_addr_a = addr; load_data_a = data;
    end else begin
      model_b[addr] = data;
      load_en_b = 1'b1; load_addr_b = addr; load_data_b = data;
    end
    @(negedge clk);
    load_en_a = 1'b0;
    load_en_b = 1'b0;
  endtask

  // Each rising edge of valueReady retires the oldest expected load.
  always @(negedge clk) begin
    if (bus_a.valueReady === 1'b1 && vr_prev_a == 1'b0) begin
      if (exp_a.size() == 0) checkOutput("a_unexpected_load", 32'd1, 32'd0);
      else checkOutput("a_load", 32'(bus_a.memLoadVal), 32'(exp_a.pop_front()));
    end
    if (bus_b.valueReady === 1'b1 && vr_prev_b == 1'b0) begin
      if (exp_b.size() == 0) checkOutput("b_unexpected_load", 32'd1, 32'd0);
      else checkOutput("b_load", 32'(bus_b.memLoadVal), 32'(exp_b.pop_front()));
    end
    vr_prev_a <= (bus_a.valueReady === 1'b1);
    vr_prev_b <= (bus_b.valueReady === 1'b1);
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    instr_addr_a = 8'd0; instr_addr_b = 8'd0;
    load_en_a = 1'b0; load_addr_a = 8'd0; load_data_a = 16'd0;
    load_en_b = 1'b0; load_addr_b = 8'd0; load_data_b = 16'd0;
    bus_a.readReq = 1'b0; bus_a.writeReq = 1'b0;
    bus_a.memAddrLoadStore = 8'd0; bus_a.memStoreVal = 16'd0;
    bus_b.readReq = 1'b0; bus_b.writeReq = 1'b0;
    bus_b.memAddrLoadStore = 8'd0; bus_b.memStoreVal = 16'd0;
    repeat (2) @(negedge clk);

    // Preloads land while reset is held.
    applyPreload(1'b0, 8'd128, 16'h0001);
    applyPreload(1'b0, 8'd129, 16'h0000);
    applyPreload(1'b0, 8'd130, 16'h0000);
    applyPreload(1'b0, 8'd7,   16'h0000);
    applyPreload(1'b1, 8'd5,   16'h0000);
    applyPreload(1'b1, 8'd20,  16'h5555);
    applyPreload(1'b1, 8'd21,  16'h0000);

    checkOutput("rst_value_ready", 32'(bus_a.valueReady), 32'd0);
    checkOutput("rst_load_val", 32'(bus_a.memLoadVal), 32'd0);
    checkOutput("rst_busy", 32'(bus_a.busy), 32'd0);
    checkOutput("rst_overflow", 32'(bus_a.reqOverflow), 32'd0);
    instr_addr_a = 8'd128;
    #1 checkOutput("preload_instr", 32'(instr_a), 32'h0001);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // Plain read with default latency.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd128, 16'h0000);
    checkOutput("rd_vr_n", 32'(bus_a.valueReady), 32'd0);
    checkOutput("rd_busy_n", 32'(bus_a.busy), 32'd1);
    @(negedge clk);
    checkOutput("rd_vr_n1", 32'(bus_a.valueReady), 32'd0);
    @(negedge clk);
    checkOutput("rd_vr_n2", 32'(bus_a.valueReady), 32'd1);
    checkOutput("rd_busy_n2", 32'(bus_a.busy), 32'd0);

    // Write then read back through both ports.
    instr_addr_a = 8'd130;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd130, 16'h00A5);
    checkOutput("wr_instr_before", 32'(instr_a), 32'h0000);
    checkOutput("wr_busy", 32'(bus_a.busy), 32'd1);
    @(negedge clk);
    checkOutput("wr_instr_after", 32'(instr_a), 32'h00A5);
    checkOutput("wr_busy_done", 32'(bus_a.busy), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd130, 16'h0000);
    checkOutput("rd2_vr_drop", 32'(bus_a.valueReady), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("rd2_vr", 32'(bus_a.valueReady), 32'd1);

    // Simultaneous read and write edges: write first, read sees new data.
    instr_addr_a = 8'd129;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd129, 16'h1234);
    checkOutput("sim_vr_n", 32'(bus_a.valueReady), 32'd1);
    @(negedge clk);
    checkOutput("sim_vr_n1", 32'(bus_a.valueReady), 32'd0);
    checkOutput("sim_instr_n1", 32'(instr_a), 32'h1234);
    @(negedge clk);
    checkOutput("sim_vr_n2", 32'(bus_a.valueReady), 32'd0);
    @(negedge clk);
    checkOutput("sim_vr_n3", 32'(bus_a.valueReady), 32'd1);

    // Preload collides with a commit to the same address.
    instr_addr_a = 8'd7;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd7, 16'h0001);
    model_a[7] = 16'h0BAD;
    load_en_a = 1'b1; load_addr_a = 8'd7; load_data_a = 16'h0BAD;
    @(negedge clk);
    load_en_a = 1'b0;
    checkOutput("collide_instr", 32'(instr_a), 32'h0BAD);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd7, 16'h0000);
    repeat (3) @(negedge clk);

    // Overflow on instance b: two write edges during a long read.
    instr_addr_b = 8'd21;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd20, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd21, 16'h0011);
    checkOutput("ovf_not_yet", 32'(bus_b.reqOverflow), 32'd0);
    @(negedge clk);
    bus_b.memAddrLoadStore = 8'd21; bus_b.memStoreVal = 16'h0022; bus_b.writeReq = 1'b1;
    @(negedge clk);
    bus_b.writeReq = 1'b0;
    checkOutput("ovf_set", 32'(bus_b.reqOverflow), 32'd1);
    checkOutput("ovf_instr_n3", 32'(instr_b), 32'h0000);
    @(negedge clk);
    checkOutput("ovf_busy_n4", 32'(bus_b.busy), 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("ovf_instr_n6", 32'(instr_b), 32'h0000);
    @(negedge clk);
    checkOutput("ovf_instr_n7", 32'(instr_b), 32'h0011);
    checkOutput("ovf_busy_n7", 32'(bus_b.busy), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("ovf_instr_final", 32'(instr_b), 32'h0011);
    checkOutput("ovf_sticky", 32'(bus_b.reqOverflow), 32'd1);

    // Reset aborts an uncommitted write; readReq held across reset is an edge.
    instr_addr_b = 8'd5;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd5, 16'hFFFF);
    model_b[5] = 16'h0000;
    checkOutput("rstw_busy", 32'(bus_b.busy), 32'd1);
    rst_b = 1'b1;
    bus_b.readReq = 1'b1; bus_b.memAddrLoadStore = 8'd5;
    @(negedge clk);
    checkOutput("rstw_vr", 32'(bus_b.valueReady), 32'd0);
    checkOutput("rstw_busy0", 32'(bus_b.busy), 32'd0);
    checkOutput("rstw_overflow", 32'(bus_b.reqOverflow), 32'd0);
    checkOutput("rstw_load_val", 32'(bus_b.memLoadVal), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("rstw_mem5", 32'(instr_b), 32'h0000);
    exp_b.push_back(model_b[5]);
    rst_b = 1'b0;
    @(negedge clk);
    bus_b.readReq = 1'b0;
    checkOutput("held_rd_busy", 32'(bus_b.busy), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("held_rd_vr_p3", 32'(bus_b.valueReady), 32'd0);
    @(negedge clk);
    checkOutput("held_rd_vr_p4", 32'(bus_b.valueReady), 32'd1);

    repeat (3) @(negedge clk);
    checkOutput("sb_a_empty", 32'(exp_a.size()), 32'd0);
    checkOutput("sb_b_empty", 32'(exp_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
